// File: rtl/clk_div_pkg.sv
// Shared definitions for the clock/enable generator.
//   MODE_*     : encoding of the 2-bit requested/current mode
//   state_e    : CPU clock FSM states
//   sel_width  : width of a bit-index into a counter of the given width
package clk_div_pkg;

    localparam logic [1:0] MODE_FAST  = 2'b00;
    localparam logic [1:0] MODE_SLOW  = 2'b01;
    localparam logic [1:0] MODE_PAUSE = 2'b10;
    localparam logic [1:0] MODE_STEP  = 2'b11;

    typedef enum logic [1:0] {
        S_FAST,
        S_SLOW,
        S_PAUSE,
        S_STEP_HI
    } state_e;

    function automatic int unsigned sel_width(input int unsigned w);
        int unsigned r;
        r = $clog2(w);
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One programmable tick channel: a down-counter that pulses tick for one cycle
// each time it reaches zero, then reloads from the stored divide value.
//   clk      in  system clock
//   rst      in  asynchronous active-high reset
//   div_val  in  divide value, captured on div_load
//   div_load in  store div_val and restart the count from it
//   tick     out one-cycle pulse every div_val+1 cycles
module clk_div_chan #(
    parameter int unsigned DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] div_val,
    input  logic             div_load,
    output logic             tick
);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] cnt_q;
    logic             run_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (div_load) begin
            div_q <= div_val;
            cnt_q <= div_val;
            run_q <= 1'b1;
        end else if (cnt_q == '0) begin
            cnt_q <= div_q;
        end else begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    // Idle until first load so a freshly reset channel stays silent; a load
    // in the zero-count cycle restarts the period instead of ticking.
    assign tick = run_q && (cnt_q == '0) && !div_load;

endmodule

// File: rtl/clk_div_ctrl.sv
// Clock/enable generator: free-running divide counter, glitch-free CPU clock
// selection between FAST/SLOW/PAUSE/STEP, and NCH programmable tick channels.
//   clk, rst   in  system clock, asynchronous active-high reset
//   clkdiv     out free-running counter
//   fast_sel   in  clkdiv bit index for FAST mode
//   slow_sel   in  clkdiv bit index for SLOW mode
//   mode       in  requested mode (00 FAST, 01 SLOW, 10 PAUSE, 11 STEP)
//   step       in  asynchronous single-step request level
//   clk_cpu    out registered CPU clock
//   cpu_rise   out one-cycle pulse with each clk_cpu rising edge
//   cur_mode   out mode currently in effect
//   div_val    in  packed per-channel divide values
//   div_load   in  per-channel load strobes
//   tick       out per-channel tick pulses
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned NCH      = 4,
    parameter int unsigned DIV_W    = 16,
    parameter int unsigned STEP_LEN = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    output logic [CNT_W-1:0]            clkdiv,
    input  logic [sel_width(CNT_W)-1:0] fast_sel,
    input  logic [sel_width(CNT_W)-1:0] slow_sel,
    input  logic [1:0]                  mode,
    input  logic                        step,
    output logic                        clk_cpu,
    output logic                        cpu_rise,
    output logic [1:0]                  cur_mode,
    input  logic [NCH*DIV_W-1:0]        div_val,
    input  logic [NCH-1:0]              div_load,
    output logic [NCH-1:0]              tick
);

    localparam int unsigned SEL_W   = sel_width(CNT_W);
    localparam int unsigned STEP_CW = (STEP_LEN > 1) ? $clog2(STEP_LEN) : 1;

    logic [CNT_W-1:0]   clkdiv_q;
    state_e             state_q, state_d, tgt_state;
    logic [SEL_W-1:0]   sel_q, sel_d, tgt_sel;
    logic               tgt_bit;
    logic [STEP_CW-1:0] step_cnt_q, step_cnt_d;
    logic               clk_cpu_q, clk_cpu_d;
    logic               cpu_rise_q;
    logic               step_meta_q, step_sync_q, step_prev_q;
    logic               step_edge;

    assign step_edge = step_sync_q & ~step_prev_q;

    // Where the requested mode wants to go and what its source bit is now.
    always_comb begin
        tgt_state = S_PAUSE;
        tgt_sel   = sel_q;
        tgt_bit   = 1'b0;
        case (mode)
            MODE_FAST: begin
                tgt_state = S_FAST;
                tgt_sel   = fast_sel;
                tgt_bit   = clkdiv_q[fast_sel];
            end
            MODE_SLOW: begin
                tgt_state = S_SLOW;
                tgt_sel   = slow_sel;
                tgt_bit   = clkdiv_q[slow_sel];
            end
            default: begin
                tgt_state = S_PAUSE;
            end
        endcase
    end

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        step_cnt_d = step_cnt_q;
        case (state_q)
            S_STEP_HI: begin
                if (step_cnt_q == '0) begin
                    state_d = S_PAUSE;
                end else begin
                    step_cnt_d = step_cnt_q - 1'b1;
                end
            end
            default: begin
                if (state_q == S_PAUSE && mode == MODE_STEP && step_edge) begin
                    state_d    = S_STEP_HI;
                    step_cnt_d = STEP_CW'(STEP_LEN - 1);
                // Switch only with both old and new clocks low: no short phases.
                end else if (tgt_state != state_q && !clk_cpu_q && !tgt_bit) begin
                    state_d = tgt_state;
                    sel_d   = tgt_sel;
                end
            end
        endcase
    end

    // Driven from the next state so the switch cycle already uses the new source.
    always_comb begin
        clk_cpu_d = 1'b0;
        case (state_d)
            S_FAST, S_SLOW: clk_cpu_d = clkdiv_q[sel_d];
            S_STEP_HI:      clk_cpu_d = 1'b1;
            default:        clk_cpu_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clkdiv_q    <= '0;
            state_q     <= S_PAUSE;
            sel_q       <= '0;
            step_cnt_q  <= '0;
            clk_cpu_q   <= 1'b0;
            cpu_rise_q  <= 1'b0;
            step_meta_q <= 1'b0;
            step_sync_q <= 1'b0;
            step_prev_q <= 1'b0;
        end else begin
            clkdiv_q    <= clkdiv_q + 1'b1;
            state_q     <= state_d;
            sel_q       <= sel_d;
            step_cnt_q  <= step_cnt_d;
            clk_cpu_q   <= clk_cpu_d;
            cpu_rise_q  <= clk_cpu_d & ~clk_cpu_q;
            step_meta_q <= step;
            step_sync_q <= step_meta_q;
            step_prev_q <= step_sync_q;
        end
    end

    always_comb begin
        cur_mode = MODE_PAUSE;
        case (state_q)
            S_FAST:  cur_mode = MODE_FAST;
            S_SLOW:  cur_mode = MODE_SLOW;
            default: cur_mode = (mode == MODE_STEP) ? MODE_STEP : MODE_PAUSE;
        endcase
    end

    assign clkdiv   = clkdiv_q;
    assign clk_cpu  = clk_cpu_q;
    assign cpu_rise = cpu_rise_q;

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        clk_div_chan #(
            .DIV_W(DIV_W)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .div_val  (div_val[i*DIV_W +: DIV_W]),
            .div_load (div_load[i]),
            .tick     (tick[i])
        );
    end

endmodule

// File: tb/tb_clk_div_ctrl.sv
module tb_clk_div_ctrl;
    import clk_div_pkg::*;

    logic        clk;
    logic        rst;
    logic [31:0] clkdiv;
    logic [4:0]  fast_sel;
    logic [4:0]  slow_sel;
    logic [1:0]  mode;
    logic        step;
    logic        clk_cpu;
    logic        cpu_rise;
    logic [1:0]  cur_mode;
    logic [63:0] div_val;
    logic [3:0]  div_load;
    logic [3:0]  tick;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit mon   = 0;
    int hi_cnt, rise_cnt, tick_cnt, run_len, min_hi;

    clk_div_ctrl #(
        .CNT_W    (32),
        .NCH      (4),
        .DIV_W    (16),
        .STEP_LEN (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .clkdiv   (clkdiv),
        .fast_sel (fast_sel),
        .slow_sel (slow_sel),
        .mode     (mode),
        .step     (step),
        .clk_cpu  (clk_cpu),
        .cpu_rise (cpu_rise),
        .cur_mode (cur_mode),
        .div_val  (div_val),
        .div_load (div_load),
        .tick     (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        hi_cnt   = 0;
        rise_cnt = 0;
        tick_cnt = 0;
        run_len  = 0;
        min_hi   = 1000;
    endtask

    // Advance to cycle k (counted in rising edges since reset release),
    // sampling on the falling edge.
    task automatic run_until(input int k);
        while (cyc < k) begin
            @(negedge clk);
            cyc++;
            if (mon) begin
                if (clk_cpu) begin
                    hi_cnt++;
                    run_len++;
                end else begin
                    if (run_len != 0 && run_len < min_hi) min_hi = run_len;
                    run_len = 0;
                end
                rise_cnt += int'(cpu_rise);
                tick_cnt += int'(tick[0]);
            end
        end
    endtask

    initial begin
        rst      = 1'b0;
        mode     = MODE_FAST;
        fast_sel = 5'd3;
        slow_sel = 5'd6;
        step     = 1'b0;
        div_val  = '0;
        div_load = '0;
        clear_mon();
        #2 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_clkdiv", clkdiv, 0);
        check("rst_clk_cpu", clk_cpu, 0);
        check("rst_cpu_rise", cpu_rise, 0);
        check("rst_cur_mode", cur_mode, MODE_PAUSE);
        check("rst_tick", tick, 0);
        rst = 1'b0;
        cyc = 0;

        // FAST, sel=3
        run_until(1);   check("fast_mode", cur_mode, MODE_FAST);
        run_until(8);   check("fast_lo8", clk_cpu, 0); check("clkdiv8", clkdiv, 8);
        run_until(9);   check("fast_hi9", clk_cpu, 1); check("rise9", cpu_rise, 1);
        run_until(10);  check("rise10", cpu_rise, 0);
        run_until(16);  check("fast_hi16", clk_cpu, 1);
        run_until(17);  check("fast_lo17", clk_cpu, 0);
        run_until(25);  check("rise25", cpu_rise, 1);

        // FAST -> SLOW requested while clk_cpu is high
        run_until(58);  check("pre_slow_hi", clk_cpu, 1);
        mode = MODE_SLOW;
        run_until(64);
        clear_mon();
        mon = 1;
        run_until(128); check("still_fast_hi", clk_cpu, 1); check("mode128", cur_mode, MODE_FAST);
        run_until(129); check("lo129", clk_cpu, 0); check("mode129", cur_mode, MODE_FAST);
        run_until(130); check("mode130", cur_mode, MODE_SLOW);
        run_until(192); check("slow_lo192", clk_cpu, 0);
        run_until(193); check("slow_hi193", clk_cpu, 1); check("rise193", cpu_rise, 1);
        run_until(256); check("slow_hi256", clk_cpu, 1);
        run_until(257); check("slow_lo257", clk_cpu, 0);
        mon = 0;
        check("switch_hi_cycles", hi_cnt, 96);
        check("switch_min_high", min_hi, 8);

        // STEP mode
        mode = MODE_STEP;
        clear_mon();
        mon = 1;
        run_until(258); check("step_mode", cur_mode, MODE_STEP); check("pause_lo", clk_cpu, 0);
        run_until(260); step = 1'b1;
        run_until(262); check("step_lo262", clk_cpu, 0);
        run_until(263); check("step_hi263", clk_cpu, 1); check("step_rise", cpu_rise, 1);
        run_until(265); step = 1'b0;
        run_until(267); step = 1'b1;
        run_until(270); check("step_hi270", clk_cpu, 1); step = 1'b0;
        run_until(271); check("step_lo271", clk_cpu, 0);
        run_until(276); check("step_dropped", clk_cpu, 0);
        run_until(360); step = 1'b1;
        run_until(363); check("step2_hi", clk_cpu, 1);
        run_until(365); step = 1'b0;
        run_until(371); check("step2_lo", clk_cpu, 0);
        run_until(460); step = 1'b1;
        run_until(465); step = 1'b0;
        run_until(500);
        mon = 0;
        check("step_hi_cycles", hi_cnt, 24);
        check("step_rises", rise_cnt, 3);

        // Tick channel 0: div 4, then reload with 0
        div_val  = 64'd4;
        div_load = 4'b0001;
        run_until(501);
        div_load = 4'b0000;
        clear_mon();
        mon = 1;
        run_until(504); check("tick504", tick, 4'b0000);
        run_until(505); check("tick505", tick, 4'b0001);
        run_until(506); check("tick506", tick, 4'b0000);
        run_until(510); check("tick510", tick, 4'b0001);
        run_until(525);
        mon = 0;
        check("tick_count", tick_cnt, 5);
        run_until(527);
        div_val  = 64'd0;
        div_load = 4'b0001;
        #1 check("reload_cycle", tick, 4'b0000);
        run_until(528); div_load = 4'b0000;
        #1 check("div0_528", tick, 4'b0001);
        run_until(529); check("div0_529", tick, 4'b0001);
        run_until(530); div_load = 4'b0001;
        #1 check("load_wins", tick, 4'b0000);
        run_until(531); div_load = 4'b0000;
        #1 check("div0_531", tick, 4'b0001);

        // Reset during STEP_HI
        run_until(540); step = 1'b1;
        run_until(543); check("sh_hi543", clk_cpu, 1); step = 1'b0;
        run_until(545); check("sh_hi545", clk_cpu, 1); check("tick545", tick, 4'b0001);
        rst  = 1'b1;
        mode = MODE_FAST;
        #1;
        check("arst_clk_cpu", clk_cpu, 0);
        check("arst_clkdiv", clkdiv, 0);
        check("arst_tick", tick, 0);
        check("arst_rise", cpu_rise, 0);
        check("arst_mode", cur_mode, MODE_PAUSE);
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        #1 check("rel_mode", cur_mode, MODE_PAUSE);
        run_until(1);  check("rel_fast", cur_mode, MODE_FAST);
        run_until(5);  check("rel_tick", tick, 0);
        run_until(9);  check("rel_hi9", clk_cpu, 1);

        // Reset during FAST
        run_until(12);
        rst = 1'b1;
        #1;
        check("frst_clk_cpu", clk_cpu, 0);
        check("frst_clkdiv", clkdiv, 0);
        check("frst_mode", cur_mode, MODE_PAUSE);
        @(negedge clk);
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clk_div_ctrl.md
# clk_div_ctrl

Parametrised clock/enable generator that replaces the single fixed divider in front of the CPU. It keeps a free-running divide counter, derives the CPU clock from a run-time selectable counter bit, and switches glitch-free between fast, slow, pause and single-step modes. It also provides NCH independent programmable tick channels for display scanning, debouncing and timers. It sits at the top level between the board oscillator and the CPU, display and peripheral blocks.

## Interface
- CNT_W, 32: width of free-running counter `clkdiv`.
- NCH, 4: number of programmable tick channels.
- DIV_W, 16: width of each channel divide value.
- STEP_LEN, 8: `clk` cycles `clk_cpu` stays high per single step (≥1).
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- clkdiv  out  CNT_W  free-running counter, +1 per `clk`.
- fast_sel  in  $clog2(CNT_W)  `clkdiv` bit index used in FAST mode.
- slow_sel  in  $clog2(CNT_W)  `clkdiv` bit index used in SLOW mode.
- mode  in  2  requested mode: 00 FAST, 01 SLOW, 10 PAUSE, 11 STEP.
- step  in  1  single-step request, asynchronous level.
- clk_cpu  out  1  registered CPU clock.
- cpu_rise  out  1  one-cycle pulse, coincident with `clk_cpu` 0→1.
- cur_mode  out  2  mode currently in effect.
- div_val  in  NCH*DIV_W  per-channel divide value, channel i at [i*DIV_W +: DIV_W].
- div_load  in  NCH  per-channel load strobe.
- tick  out  NCH  per-channel one-cycle pulse, one every div+1 cycles.

## Operation
- Reset values: `clkdiv`=0, `clk_cpu`=0, `cpu_rise`=0, `cur_mode`=PAUSE (state S_PAUSE), all channel counters=0, div registers=0, `tick`=0. The step synchroniser and edge-detect flops also clear to 0.
- `clkdiv` wraps from all-ones to 0 silently.
- FSM states: S_FAST, S_SLOW, S_PAUSE, S_STEP_HI.
- S_FAST / S_SLOW: `clk_cpu` <= `clkdiv[sel]`, where sel is `fast_sel` or `slow_sel`.
- S_PAUSE: `clk_cpu` held 0.
- S_STEP_HI: `clk_cpu` held 1 for STEP_LEN cycles, then the FSM returns to S_PAUSE.
- Mode switch from S_FAST, S_SLOW or S_PAUSE to the state requested by `mode` is taken only when all of these hold in the same cycle:
  - `clk_cpu`==0.
  - The source bit of the new mode is 0 (PAUSE and STEP count as 0).
  - Result: no truncated high or low phase.
- STEP and PAUSE both map to S_PAUSE.
- Step handling:
  - `step` passes through a 2-flop synchroniser, then a rising-edge detect.
  - An edge while in S_PAUSE with `mode`==STEP enters S_STEP_HI.
  - Edges in any other state or mode are dropped, not queued.
- S_STEP_HI ignores `mode` changes until it exits.
- `cur_mode` reports STEP, not PAUSE, while `mode`==STEP and the FSM is in S_PAUSE or S_STEP_HI.
- `fast_sel` / `slow_sel` changes take effect at the next eligible switch point only. The active select is latched on entry to the run state.
- Tick channel i:
  - Down-counter. `tick[i]`=1 in the cycle the counter is 0, and the counter reloads with the stored div value.
  - div=0 gives `tick[i]` every cycle.
  - `div_load[i]` stores the new value and loads the counter with it; the first tick follows div+1 cycles after the load.
  - Load in the same cycle as a zero count: load wins and no tick is issued.

## Timing
- `clk_cpu` lags the selected `clkdiv` bit by exactly 1 `clk`.
- `cpu_rise` is registered and aligned with `clk_cpu`.
- Mode switch latency: 1 cycle from the eligible cycle to the new state. Worst case is one full period of the old source plus the new source's low phase.
- Step: synchronised edge at cycle t gives `clk_cpu`=1 over t+1..t+STEP_LEN and 0 at t+STEP_LEN+1.
- Tick: a load at cycle t with value d gives pulses at t+d+1, t+2(d+1), …
- `rst` mid-operation: all outputs take their reset values immediately (asynchronous); release resumes in S_PAUSE.

## Structure
- Package `clk_div_pkg`:
  - Mode encoding constants MODE_FAST/SLOW/PAUSE/STEP.
  - FSM state enum.
  - Function computing the select width.
- Sub-module `clk_div_chan` (one tick channel), generated NCH times.
- Top: counter, synchroniser, FSM, output registers.

## Test plan
- Reset, mode=FAST, fast_sel=3 → `clk_cpu` toggles every 8 `clk`, 1 cycle behind `clkdiv[3]`; `cpu_rise` pulses every 16.
- FAST(sel=3)→SLOW(sel=6) requested while `clk_cpu`=1 → switch occurs only once `clk_cpu`=0 and `clkdiv[6]`=0; no `clk_cpu` high phase shorter than 8 cycles.
- mode=STEP, three `step` pulses 100 cycles apart, STEP_LEN=8 → exactly three 8-cycle highs, each starting 3 cycles after the `step` rise. A `step` during STEP_HI is dropped.
- Channel 0 loaded with 4 → `tick[0]` every 5 cycles; reload with 0 mid-count → `tick[0]` every cycle starting 1 cycle after the load.
- Assert `rst` during STEP_HI and during FAST → `clk_cpu`=0, `clkdiv`=0, `tick`=0 in the same cycle; after release, `cur_mode`=PAUSE until the requested mode is eligible.
